// File: rtl/sram_req_arbiter.sv
// Two-master (IF instruction / EX data) arbiter onto one SRAM-like slave, with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data has fixed priority.
module sram_req_arbiter #(
    parameter int OUTS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam int PW = $clog2(OUTS_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_ids [OUTS_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_count;

    logic            w_full;
    logic            w_gnt_vld;
    logic            w_gnt_id;
    logic            w_sel_req;
    logic            w_push;
    logic            w_pop;
    logic            w_head_id;
    logic            w_both_pick;

`ifdef SRAM_ARB_RR_EN
    // Last handshake winner; reset to inst so data is preferred first.
    logic            r_last_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_last_win <= 1'b0;
        else if (w_push) r_last_win <= w_gnt_id;
    end

    assign w_both_pick = ~r_last_win;
`else
    assign w_both_pick = 1'b1;
`endif

    assign w_full = (r_count == (PW+1)'(OUTS_DEPTH));

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_full) begin
                    if (inst_req && data_req) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = w_both_pick;
                    end else if (data_req) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = 1'b1;
                    end else if (inst_req) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = 1'b0;
                    end
                end
            end
            LOCK_I: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end
            LOCK_D: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
            default: begin
                w_gnt_vld = 1'b0;
                w_gnt_id  = 1'b0;
            end
        endcase
    end

    assign w_sel_req = w_gnt_id ? data_req : inst_req;
    assign sram_req  = w_gnt_vld & w_sel_req & ~w_full;

    // A locked master that drops req before addr_ok releases the lock without a push.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (sram_req && !sram_addr_ok)
                    w_state_nxt = w_gnt_id ? LOCK_D : LOCK_I;
            end
            LOCK_I, LOCK_D: begin
                if (!w_sel_req || sram_addr_ok)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    assign sram_wr    = w_gnt_id ? data_wr    : inst_wr;
    assign sram_size  = w_gnt_id ? data_size  : inst_size;
    assign sram_wstrb = w_gnt_id ? data_wstrb : inst_wstrb;
    assign sram_addr  = w_gnt_id ? data_addr  : inst_addr;
    assign sram_wdata = w_gnt_id ? data_wdata : inst_wdata;

    assign inst_addr_ok = sram_addr_ok & sram_req & ~w_gnt_id;
    assign data_addr_ok = sram_addr_ok & sram_req &  w_gnt_id;

    assign w_push    = sram_req & sram_addr_ok;
    assign w_pop     = sram_data_ok & (r_count != '0);
    assign w_head_id = r_ids[r_rptr];

    assign inst_data_ok = w_pop & ~w_head_id;
    assign data_data_ok = w_pop &  w_head_id;
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    // Issue-order FIFO of master IDs: control state reset, storage left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_ids[r_wptr] <= w_gnt_id;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized and directed bench for sram_req_arbiter against a queue-based behavioural model.
// Honors SRAM_ARB_RR_EN the same way the design does.
module tb_sram_req_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [3:0]  inst_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [3:0]  data_wstrb = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok = 0, sram_data_ok = 0;
    logic [31:0] sram_rdata = 0;

    sram_req_arbiter #(.OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
        .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding owners in issue order, current lock owner, last winner.
    int q[$];
    int lock_own = -1;
    bit last_win = 1'b0;
    int e_owner;
    bit e_req, e_push, e_pop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic eval_cmp();
        bit full;
        bit [1:0] rq;
        int own;
        int head;
        #2;
        rq   = {data_req, inst_req};
        full = (q.size() == DEPTH);
        own  = -1;
        if (lock_own >= 0) begin
            own = lock_own;
        end else if (!full) begin
            if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
                own = last_win ? 0 : 1;
`else
                own = 1;
`endif
            end else if (data_req) own = 1;
            else if (inst_req)     own = 0;
        end
        e_owner = own;
        e_req   = (own >= 0) && rq[own] && !full;
        e_push  = e_req && sram_addr_ok;
        e_pop   = sram_data_ok && (q.size() > 0);
        head    = (q.size() > 0) ? q[0] : 0;
        check_eq("sram_req", {31'd0, sram_req}, {31'd0, e_req});
        check_eq("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_push && own == 0});
        check_eq("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_push && own == 1});
        check_eq("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_pop && head == 0});
        check_eq("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_pop && head == 1});
        check_eq("sram_addr", sram_addr, (own == 1) ? data_addr : inst_addr);
        check_eq("sram_wdata", sram_wdata, (own == 1) ? data_wdata : inst_wdata);
        check_eq("sram_ctl", {25'd0, sram_wr, sram_size, sram_wstrb},
                 (own == 1) ? {25'd0, data_wr, data_size, data_wstrb}
                            : {25'd0, inst_wr, inst_size, inst_wstrb});
        check_eq("rdata", {inst_rdata ^ data_rdata}, 32'd0);
        check_eq("inst_rdata", inst_rdata, sram_rdata);
    endtask

    task automatic advance();
        bit owner_req;
        owner_req = (e_owner == 1) ? data_req : inst_req;
        @(posedge clk);
        #1;
        if (e_pop) void'(q.pop_front());
        if (e_push) begin
            q.push_back(e_owner);
            last_win = (e_owner == 1);
        end
        if (lock_own >= 0) begin
            if (!owner_req || sram_addr_ok) lock_own = -1;
        end else if (e_req && !sram_addr_ok) begin
            lock_own = e_owner;
        end
    endtask

    task automatic set_in(input bit ir, input bit dr, input bit ao, input bit dk);
        inst_req     = ir;
        data_req     = dr;
        sram_addr_ok = ao;
        sram_data_ok = dk;
        inst_addr    = $urandom;
        data_addr    = $urandom;
        inst_wdata   = $urandom;
        data_wdata   = $urandom;
        sram_rdata   = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 1);
        q.delete();
        lock_own = -1;
        last_win = 1'b0;
        #2;
        check_eq("rst_sram_req", {31'd0, sram_req}, 32'd0);
        check_eq("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check_eq("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check_eq("rst_addr_mux", sram_addr, inst_addr);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sram_data_ok = 1'b0;
    endtask

    task automatic cyc(input bit ir, input bit dr, input bit ao, input bit dk);
        set_in(ir, dr, ao, dk);
        eval_cmp();
        advance();
    endtask

    task automatic rnd_cycle(input int preq, input int pa, input int pd);
        inst_wr    = $urandom_range(0, 1);
        data_wr    = $urandom_range(0, 1);
        inst_size  = 2'($urandom_range(0, 3));
        data_size  = 2'($urandom_range(0, 3));
        inst_wstrb = 4'($urandom_range(0, 15));
        data_wstrb = 4'($urandom_range(0, 15));
        set_in(0, 0, 0, 0);
        inst_req     = (lock_own == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 99) < preq);
        data_req     = (lock_own == 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 99) < preq);
        sram_addr_ok = ($urandom_range(0, 99) < pa);
        sram_data_ok = ($urandom_range(0, 99) < pd);
        eval_cmp();
        advance();
    endtask

    initial begin
        #1;
        do_reset();

        // single inst read
        set_in(1, 0, 1, 0);
        inst_addr = 32'h1c000000;
        eval_cmp();
        check_eq("t1_inst_aok", {31'd0, inst_addr_ok}, 32'd1);
        check_eq("t1_sram_addr", sram_addr, 32'h1c000000);
        advance();
        cyc(0, 0, 0, 0);
        set_in(0, 0, 0, 1);
        sram_rdata = 32'h02800c0c;
        eval_cmp();
        check_eq("t1_inst_dok", {31'd0, inst_data_ok}, 32'd1);
        check_eq("t1_data_dok", {31'd0, data_data_ok}, 32'd0);
        check_eq("t1_rdata", inst_rdata, 32'h02800c0c);
        advance();

        // simultaneous requests, data locked for 3 cycles
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 0, 0);
            eval_cmp();
            check_eq("t2_lockd_addr", sram_addr, data_addr);
            advance();
        end
        set_in(1, 1, 1, 0);
        eval_cmp();
        check_eq("t2_data_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        advance();
        set_in(1, 0, 0, 0);
        eval_cmp();
        check_eq("t2_inst_next", {31'd0, sram_req}, 32'd1);
        check_eq("t2_inst_addr", sram_addr, inst_addr);
        advance();
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // out-of-type ordering
        do_reset();
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 1);
            eval_cmp();
            check_eq("t3_order", {30'd0, data_data_ok, inst_data_ok}, (k == 1) ? 32'd2 : 32'd1);
            advance();
        end

        // FIFO full
        do_reset();
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            set_in(1, 0, 1, 0);
            eval_cmp();
            check_eq("t4_full_block", {31'd0, sram_req}, 32'd0);
            advance();
        end
        set_in(1, 0, 1, 1);
        eval_cmp();
        check_eq("t4_pop_noblock", {31'd0, sram_req}, 32'd0);
        check_eq("t4_pop_dok", {31'd0, inst_data_ok}, 32'd1);
        advance();
        set_in(1, 0, 1, 0);
        eval_cmp();
        check_eq("t4_resume", {31'd0, inst_addr_ok}, 32'd1);
        advance();
        for (int k = 0; k < DEPTH; k++) cyc(0, 0, 0, 1);

        // reset mid-flight drops outstanding IDs
        do_reset();
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 1);
            eval_cmp();
            check_eq("t5_no_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            advance();
        end

        // continuous dual requests
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 1, 1, 1);
            eval_cmp();
`ifdef SRAM_ARB_RR_EN
            check_eq("t6_rr_owner", sram_addr, (k % 2 == 0) ? data_addr : inst_addr);
`else
            check_eq("t6_fixed_owner", sram_addr, data_addr);
`endif
            advance();
        end
        for (int k = 0; k < 2; k++) cyc(0, 0, 0, 1);

        // randomized traffic in phases of varying pressure
        for (int ph = 0; ph < 8; ph++) begin
            int preq, pa, pd;
            preq = $urandom_range(30, 95);
            pa   = $urandom_range(10, 90);
            pd   = (ph % 2 == 0) ? $urandom_range(5, 30) : $urandom_range(40, 90);
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 299) == 0) do_reset();
                else rnd_cycle(preq, pa, pd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-master SRAM-like bus arbiter between the IF-stage instruction port and the EX-stage data port, driving a single shared SRAM-like slave port (bridge/cache side). It grants one request handshake at a time and holds the grant until `addr_ok`. It tracks outstanding transactions in issue order so each slave `data_ok` is routed back to the master that issued it. It sits between the pipeline (IF/EX request, MEM/ID response) and the memory bridge.

## Interface
- `OUTS_DEPTH`, default 4: maximum number of accepted-but-unanswered transactions; power of two, 2..16.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1 each  instruction master request and write flag.
- `inst_size`  in  2  instruction master access size.
- `inst_wstrb`  in  4  instruction master byte write strobes.
- `inst_addr`, `inst_wdata`  in  32 each  instruction master address and write data.
- `inst_addr_ok`, `inst_data_ok`  out  1 each  instruction master request accepted / response valid.
- `inst_rdata`  out  32  instruction master read data.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`  same widths/directions as the `inst_*` set; data master (EX/MEM).
- `sram_req`, `sram_wr`  out  1 each  slave request and write flag.
- `sram_size`  out  2  slave access size.
- `sram_wstrb`  out  4  slave byte write strobes.
- `sram_addr`, `sram_wdata`  out  32 each  slave address and write data.
- `sram_addr_ok`, `sram_data_ok`  in  1 each  slave accept / response.
- `sram_rdata`  in  32  slave read data.

## Operation
- Grant FSM states: IDLE, LOCK_I, LOCK_D.
  - IDLE: if a master requests and the FIFO is not full, grant it combinationally in the same cycle.
  - IDLE, both request: data wins (see Configuration).
  - IDLE, grant without `sram_addr_ok` that cycle: go to LOCK_I / LOCK_D.
  - LOCK_x: keep granting master x only. Return to IDLE on the cycle `sram_addr_ok`=1.
  - A LOCK_x master that drops `req` before `addr_ok` is a protocol violation; the FSM returns to IDLE with no FIFO push.
- Slave request fields (`sram_wr/size/wstrb/addr/wdata`) mux from the granted master. `sram_req` = granted master's req & ~fifo_full.
- `x_addr_ok` = `sram_addr_ok` & `sram_req` & (grant==x). It is never asserted to the non-granted master.
- Handshake (`sram_req` & `sram_addr_ok`) pushes the master ID (0=inst, 1=data) into the order FIFO.
- `sram_data_ok` with FIFO non-empty:
  - pulse `x_data_ok` for the head ID;
  - pop the head.
- `sram_data_ok` with FIFO empty: ignored; no master `data_ok`, count unchanged.
- `inst_rdata` = `data_rdata` = `sram_rdata` (broadcast); only the owning master's `data_ok` qualifies it.
- FIFO:
  - circular, read/write pointers of log2(OUTS_DEPTH) bits that wrap to 0;
  - count is log2(OUTS_DEPTH)+1 bits;
  - full = count==OUTS_DEPTH; when full, no new grant is issued and `sram_req`=0.
  - A pop in the same cycle does not unblock the grant; the grant resumes the next cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.

## Timing
- Reset (asynchronous): FSM=IDLE, FIFO pointers and count=0, round-robin pointer=0.
- Reset values of outputs: `sram_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` = 0. Mux outputs follow the inst master inputs.
- Request path is combinational. Zero-cycle arbitration: `x_req` to `sram_req` in the same cycle.
- Response path is combinational. `sram_data_ok` to `x_data_ok` in the same cycle.
- Reset asserted mid-transaction: all outstanding IDs are dropped immediately. Later slave `data_ok` pulses are ignored per the empty-FIFO rule.
- At most one push and one pop per cycle.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-winner register updates on each handshake.
  - On a simultaneous IDLE request, the master that did not win last is granted.
  - Reset value of the last-winner register: inst won last, so data is preferred first.
- `SRAM_ARB_RR_EN` undefined: fixed priority, data over inst; the last-winner register is absent.

## Test plan
- Single inst read: `inst_req`=1, addr 0x1c000000, `sram_addr_ok` same cycle → `inst_addr_ok`=1 that cycle. `sram_data_ok` 2 cycles later with rdata 0x02800c0c → `inst_data_ok`=1, `data_data_ok`=0.
- Simultaneous requests, fixed priority: both `req`=1, `addr_ok` held low 3 cycles → `sram_addr`=`data_addr` every cycle (LOCK_D). Inst is granted the cycle after the data handshake.
- Out-of-type ordering: issue inst, data, inst handshakes back-to-back, then 3 `sram_data_ok` pulses → `data_ok` sequence inst, data, inst.
- FIFO full, OUTS_DEPTH=4: 4 handshakes with no `data_ok`, then a 5th request → `sram_req`=0 until the cycle after the first `data_ok`.
- Reset mid-flight: 2 outstanding, assert `reset` 1 cycle, then 2 `sram_data_ok` pulses → no master `data_ok`, count stays 0.
- `SRAM_ARB_RR_EN`: both masters request continuously with `addr_ok`=1 → grants alternate data, inst, data, inst.
